mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage: launches one data-memory request per
// access, stalls the pipeline until the memory acknowledges, and returns
// sign/zero-extended load data in the cycle after the acknowledge.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        busywait_o,
  output logic [31:0] rd_data_o,
  output logic        access_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_busy;
  logic        w_access;
  logic        w_err;
  logic        w_start;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_rd_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  logic        r_req;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_is_load;

  // A read and write together is handled as a write (mem_write_i wins below).
  assign w_access = mem_read_i | mem_write_i;

  // Decode illegal sizes and misalignment; raised only for a real access.
  always_comb begin
    w_err = 1'b0;
    if (w_access) begin
      case (funct3_i)
        3'b011, 3'b110, 3'b111: w_err = 1'b1;
        3'b001, 3'b101:         w_err = alu_out_i[0];
        3'b010:                 w_err = (alu_out_i[1:0] != 2'b00);
        default:                w_err = 1'b0;
      endcase
    end
  end

  assign w_start = w_access & ~w_err;

  // Store lane strobes and lane-replicated store data.
  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = rs2_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << alu_out_i[1:0];
        w_wdata = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {alu_out_i[1], 1'b0};
        w_wdata = {2{rs2_i[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = rs2_i;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and stall decode; stall is forced low during reset.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_busy       = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (dmem_ack_i) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (rst_i) w_busy = 1'b0;
  end

  // Request launch, hold and completion; load data captured only on ack in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_wstrb     <= 4'b0000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_load_data <= 32'h0;
      r_f3        <= 3'b000;
      r_off       <= 2'b00;
      r_is_load   <= 1'b0;
    end else if (r_state == S_IDLE && w_start) begin
      r_req     <= 1'b1;
      r_we      <= mem_write_i;
      r_wstrb   <= mem_write_i ? w_strb : 4'b0000;
      r_addr    <= {alu_out_i[31:2], 2'b00};
      r_wdata   <= w_wdata;
      r_f3      <= funct3_i;
      r_off     <= alu_out_i[1:0];
      r_is_load <= ~mem_write_i;
    end else if (r_state == S_WAIT && dmem_ack_i) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_wstrb     <= 4'b0000;
      r_load_data <= dmem_rdata_i;
    end
  end

  assign w_byte = r_load_data[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? r_load_data[31:16] : r_load_data[15:0];

  // Load formatting, presented only in DONE and only for loads.
  always_comb begin
    w_rd_data = 32'h0;
    if (r_state == S_DONE && r_is_load) begin
      case (r_f3)
        3'b000:  w_rd_data = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_rd_data = {{16{w_half[15]}}, w_half};
        3'b100:  w_rd_data = {24'h0, w_byte};
        3'b101:  w_rd_data = {16'h0, w_half};
        default: w_rd_data = r_load_data;
      endcase
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_wstrb_o = r_wstrb;
  assign busywait_o   = w_busy;
  assign rd_data_o    = w_rd_data;
  assign access_err_o = w_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, errors, long waits, reset in WAIT.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_out_i;
  logic [31:0] rs2_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        busywait_o;
  logic [31:0] rd_data_o;
  logic        access_err_o;

  int total = 0;
  int bad   = 0;

  mem_access_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .alu_out_i    (alu_out_i),
    .rs2_i        (rs2_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wstrb_o (dmem_wstrb_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .busywait_o   (busywait_o),
    .rd_data_o    (rd_data_o),
    .access_err_o (access_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One complete access: IDLE launch, nwait WAIT cycles (ack in the last), DONE, IDLE.
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                      input int nwait, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                      input logic [3:0] exp_strb, input logic [31:0] exp_rd);
    int busy_cnt;
    busy_cnt    = 0;
    mem_read_i  = rd;
    mem_write_i = wr;
    funct3_i    = f3;
    alu_out_i   = addr;
    rs2_i       = wd;
    #1;
    chk({tag, ".err"}, {31'h0, access_err_o}, 32'h0);
    chk({tag, ".req_idle"}, {31'h0, dmem_req_o}, 32'h0);
    if (busywait_o) busy_cnt++;
    tick();
    for (int k = 1; k <= nwait; k++) begin
      chk({tag, ".req"}, {31'h0, dmem_req_o}, 32'h1);
      chk({tag, ".addr"}, dmem_addr_o, exp_addr);
      chk({tag, ".we"}, {31'h0, dmem_we_o}, {31'h0, wr});
      chk({tag, ".wstrb"}, {28'h0, dmem_wstrb_o}, {28'h0, exp_strb});
      if (wr) chk({tag, ".wdata"}, dmem_wdata_o, exp_wdata);
      if (busywait_o) busy_cnt++;
      if (k == nwait) begin
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdat;
      end
      tick();
    end
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    #1;
    chk({tag, ".busy_done"}, {31'h0, busywait_o}, 32'h0);
    chk({tag, ".req_done"}, {31'h0, dmem_req_o}, 32'h0);
    chk({tag, ".rd_data"}, rd_data_o, exp_rd);
    chk({tag, ".busy_cycles"}, busy_cnt, nwait + 1);
    tick();
    chk({tag, ".rd_idle"}, rd_data_o, 32'h0);
    $display("xfer %s rd=%0b wr=%0b f3=%03b addr=%h rd_data_exp=%h busy=%0d", tag, rd, wr, f3, addr, exp_rd, busy_cnt);
  endtask

  initial begin
    rst_i        = 1'b1;
    mem_read_i   = 1'b1;
    mem_write_i  = 1'b0;
    funct3_i     = 3'b010;
    alu_out_i    = 32'h100;
    rs2_i        = 32'h0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    tick();
    tick();
    chk("rst.busy", {31'h0, busywait_o}, 32'h0);
    chk("rst.req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst.we", {31'h0, dmem_we_o}, 32'h0);
    chk("rst.wstrb", {28'h0, dmem_wstrb_o}, 32'h0);
    chk("rst.rd", rd_data_o, 32'h0);
    mem_read_i = 1'b0;
    rst_i      = 1'b0;
    tick();
    $display("reset checked");

    // Stray ack in IDLE is ignored.
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h12345678;
    tick();
    dmem_ack_i = 1'b0;
    chk("idle_ack.req", {31'h0, dmem_req_o}, 32'h0);
    chk("idle_ack.rd", rd_data_o, 32'h0);
    $display("idle ack checked");

    xfer("lw",    1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF);
    xfer("lb",    1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 1, 32'h100, 32'h0,        4'b0000, 32'hFFFFFF80);
    xfer("lbu",   1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFF7F, 1, 32'h100, 32'h0,        4'b0000, 32'h00000080);
    xfer("lh",    1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 2, 32'h100, 32'h0,        4'b0000, 32'hFFFF8001);
    xfer("lhu",   1, 0, 3'b101, 32'h102, 32'h0,        32'h80011234, 1, 32'h100, 32'h0,        4'b0000, 32'h00008001);
    xfer("lb0",   1, 0, 3'b000, 32'h200, 32'h0,        32'h80FFFF7F, 1, 32'h200, 32'h0,        4'b0000, 32'h0000007F);
    xfer("sh",    0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        1, 32'h200, 32'hABCDABCD, 4'b1100, 32'h0);
    xfer("sb",    0, 1, 3'b000, 32'h101, 32'h12345678, 32'hFFFFFFFF, 1, 32'h100, 32'h78787878, 4'b0010, 32'h0);
    xfer("sw",    0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        3, 32'h300, 32'hCAFEF00D, 4'b1111, 32'h0);
    xfer("rw",    1, 1, 3'b010, 32'h400, 32'h01020304, 32'h55555555, 1, 32'h400, 32'h01020304, 4'b1111, 32'h0);
    xfer("lw_d5", 1, 0, 3'b010, 32'h500, 32'h0,        32'h0BADF00D, 5, 32'h500, 32'h0,        4'b0000, 32'h0BADF00D);

    // Misaligned LW: error, no stall, no request.
    mem_read_i = 1'b1;
    funct3_i   = 3'b010;
    alu_out_i  = 32'h101;
    #1;
    chk("mis.err", {31'h0, access_err_o}, 32'h1);
    chk("mis.busy", {31'h0, busywait_o}, 32'h0);
    tick();
    chk("mis.req", {31'h0, dmem_req_o}, 32'h0);
    chk("mis.rd", rd_data_o, 32'h0);
    chk("mis.busy2", {31'h0, busywait_o}, 32'h0);
    funct3_i  = 3'b011;
    alu_out_i = 32'h100;
    #1;
    chk("f3_011.err", {31'h0, access_err_o}, 32'h1);
    funct3_i  = 3'b101;
    alu_out_i = 32'h103;
    #1;
    chk("hu_odd.err", {31'h0, access_err_o}, 32'h1);
    mem_read_i = 1'b0;
    funct3_i   = 3'b111;
    #1;
    chk("noacc.err", {31'h0, access_err_o}, 32'h0);
    tick();
    $display("error cases checked");

    // Reset while in WAIT; the following ack must be discarded.
    mem_read_i = 1'b1;
    funct3_i   = 3'b010;
    alu_out_i  = 32'h100;
    tick();
    chk("rstw.req_wait", {31'h0, dmem_req_o}, 32'h1);
    rst_i      = 1'b1;
    mem_read_i = 1'b0;
    #1;
    chk("rstw.busy_rst", {31'h0, busywait_o}, 32'h0);
    tick();
    rst_i        = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h11111111;
    #1;
    chk("rstw.req", {31'h0, dmem_req_o}, 32'h0);
    chk("rstw.busy", {31'h0, busywait_o}, 32'h0);
    tick();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    chk("rstw.req2", {31'h0, dmem_req_o}, 32'h0);
    chk("rstw.rd", rd_data_o, 32'h0);
    tick();
    chk("rstw.rd2", rd_data_o, 32'h0);
    $display("reset in WAIT checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
